// File: rtl/single_port_ram_ctrl.sv
// single_port_ram_ctrl
// Request-side sequencer for a single-port RAM (one access at a time).
// A valid/ready request channel goes in, and a valid/ready read-response
// channel comes out. This block is the only driver of the RAM
// data_in/addr/RWE pins.
// Optional build macro RAM_CTRL_CLEAR_EN: after reset, zero-fill the whole
// RAM (one address per cycle) before accepting requests.
module single_port_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_RWE,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_WR      = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

`ifdef RAM_CTRL_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
  // One extra bit so the counter parks at DEPTH instead of wrapping.
  localparam logic [ADDR_W:0] CLR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  logic [ADDR_W:0] r_clr_cnt;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] r_ram_din;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_rwe;
  logic              w_accept;

  // A request is taken only while the registered ready is high.
  assign w_accept = req_valid && r_req_ready;

  // Main FSM. All outputs are registered, so the RAM pins change only on
  // clock edges. The RAM address and data registers also hold the
  // captured request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RESET_STATE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_ram_din   <= '0;
      r_ram_addr  <= '0;
      r_ram_rwe   <= 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
      r_clr_cnt   <= '0;
`endif
    end else begin
      case (r_state)
`ifdef RAM_CTRL_CLEAR_EN
        S_CLEAR: begin
          if (!r_clr_cnt[ADDR_W]) begin
            r_ram_rwe  <= 1'b1;
            r_ram_addr <= r_clr_cnt[ADDR_W-1:0];
            r_ram_din  <= '0;
            r_clr_cnt  <= r_clr_cnt + CLR_ONE;
          end else begin
            // The last address was written in the cycle that just ended.
            r_ram_rwe   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
`endif
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_ram_addr  <= req_addr;
            if (req_we) begin
              r_ram_rwe <= 1'b1;
              r_ram_din <= req_wdata;
              r_state   <= S_WR;
            end else begin
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          // The RAM commits the write at this edge. Drop RWE after one cycle.
          r_ram_rwe   <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_RD_ADDR: begin
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          // RAM data_out is valid one cycle after the address was presented.
          r_rsp_rdata <= ram_data_out;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_ram_rwe   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign ram_data_in = r_ram_din;
  assign ram_addr    = r_ram_addr;
  assign ram_RWE     = r_ram_rwe;

endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// Bench for single_port_ram_ctrl. It contains a behavioural single-port
// RAM, a transaction-level expectation model checked every cycle, and a
// directed test sequence with literal expected values.
module tb_single_port_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;
  localparam int NEVER = 32'h3fffffff;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic [AW-1:0] ram_addr;
  logic          ram_RWE;

  int checks = 0;
  int failures = 0;

  single_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_data_in(ram_data_in), .ram_addr(ram_addr), .ram_RWE(ram_RWE),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, and registered read data.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_RWE) ram_mem[ram_addr] <= ram_data_in;
    ram_data_out <= ram_mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- Transaction-level model ----------------
  // Each event is given as the cycle index at which it becomes visible.
  // cyc counts the edges seen so far. Cycle c ends at edge c.
  int            cyc = 0;
  bit            m_live = 0;
  int            ready_at = NEVER, wr_at = -10, rsp_at = NEVER, clr_start = -1000;
  bit            rsp_pend = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0, rd_old = '0, rd_new = '0;
  logic [DW-1:0] shadow [DEPTH];

  function automatic bit in_clear(input int c);
    return (c >= clr_start) && (c < clr_start + DEPTH);
  endfunction
  function automatic bit e_ready(input int c);
    return m_live && !rsp_pend && (c >= ready_at);
  endfunction
  function automatic bit e_valid(input int c);
    return rsp_pend && (c >= rsp_at);
  endfunction
  function automatic logic [DW-1:0] e_rdata(input int c);
    return e_valid(c) ? rd_new : rd_old;
  endfunction
  function automatic bit e_rwe(input int c);
    return (c == wr_at) || in_clear(c);
  endfunction
  function automatic logic [AW-1:0] e_addr(input int c);
`ifdef RAM_CTRL_CLEAR_EN
    if (c < clr_start) return '0;
    if (in_clear(c)) return AW'(c - clr_start);
`endif
    return m_addr;
  endfunction
  function automatic logic [DW-1:0] e_din(input int c);
    return in_clear(c) ? '0 : m_din;
  endfunction

  // Update the model from the inputs seen at each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_live   = 1;
      rsp_pend = 0;
      rsp_at   = NEVER;
      wr_at    = -10;
      rd_old   = '0;
      rd_new   = '0;
      m_din    = '0;
`ifdef RAM_CTRL_CLEAR_EN
      clr_start = cyc + 2;
      ready_at  = cyc + 2 + DEPTH;
      m_addr    = AW'(DEPTH - 1);
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`else
      ready_at = cyc + 2;
      m_addr   = '0;
`endif
    end else if (m_live) begin
      if (e_ready(cyc) && req_valid) begin
        m_addr = req_addr;
        if (req_we) begin
          shadow[req_addr] = req_wdata;
          m_din    = req_wdata;
          wr_at    = cyc + 1;
          ready_at = cyc + 2;
        end else begin
          rd_new   = shadow[req_addr];
          rsp_pend = 1;
          rsp_at   = cyc + 3;
        end
      end else if (e_valid(cyc) && rsp_ready) begin
        rsp_pend = 0;
        rd_old   = rd_new;
        ready_at = cyc + 1;
      end
    end
    cyc++;
  end

  // Compare the DUT against the model every cycle, away from the active edge.
  int n_wr = 0;
  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready(cyc)));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid(cyc)));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata(cyc)));
      chk("ram_RWE",   32'(ram_RWE),   32'(e_rwe(cyc)));
      chk("ram_addr",  32'(ram_addr),  32'(e_addr(cyc)));
      chk("ram_din",   32'(ram_data_in), 32'(e_din(cyc)));
    end
    if (ram_RWE === 1'b1) n_wr++;
  end

  // ---------------- Directed stimulus ----------------
  // The task is called just after a negedge. It returns at the negedge
  // after acceptance.
  task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int acc);
    bit done = 0;
    acc = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 300 && !done; i++) begin
      if (req_ready === 1'b1) begin
        acc = cyc;
        done = 1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Read with rsp_ready high, and check the literal value at acceptance + 3.
  task automatic rd_check(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] v);
    int acc;
    send(1'b0, a, '0, acc);
    repeat (2) @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_data"},  32'(rsp_rdata), 32'(v));
  endtask

  initial begin
    int acc, w0, n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = '0; shadow[i] = '0; end
`ifdef RAM_CTRL_CLEAR_EN
    ram_mem[DEPTH-1] = 8'hAA;
    shadow[DEPTH-1]  = 8'hAA;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Outputs still hold their reset values in the cycle after the reset edge.
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rwe",   32'(ram_RWE),   32'd0);
    chk("rst_addr",  32'(ram_addr),  32'd0);
    @(negedge clk);
    n = 0;
    w0 = n_wr;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
`ifdef RAM_CTRL_CLEAR_EN
    chk("clear_len",  32'(n), 32'(DEPTH));
    chk("clear_wrs",  32'(n_wr - w0), 32'(DEPTH));
    rd_check("clr63", AW'(DEPTH - 1), 8'h00);
    rd_check("clr0", 6'd0, 8'h00);
    @(negedge clk);
`else
    chk("ready_after_rst", 32'(n), 32'd0);
`endif

    // Back-to-back writes. Each next request waits through the WR cycle.
    w0 = n_wr;
    send(1'b1, 6'd0, 8'h01, acc);
    send(1'b1, 6'd1, 8'h02, acc);
    send(1'b1, 6'd2, 8'h03, acc);
    @(negedge clk);
    chk("three_pulses", 32'(n_wr - w0), 32'd3);

    rd_check("rd0", 6'd0, 8'h01);
    rd_check("rd1", 6'd1, 8'h02);
    rd_check("rd2", 6'd2, 8'h03);

    // Read-after-write ordering.
    send(1'b1, 6'd1, 8'h04, acc);
    rd_check("raw1", 6'd1, 8'h04);
    @(negedge clk);

    // Response back-pressure.
    rsp_ready = 1'b0;
    w0 = n_wr;
    send(1'b0, 6'd2, '0, acc);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data",  32'(rsp_rdata), 32'h03);
      chk("hold_ready", 32'(req_ready), 32'd0);
      if (i == 3) rsp_ready = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    chk("hold_release", 32'(rsp_valid), 32'd0);
    chk("hold_nowrite", 32'(n_wr - w0), 32'd0);

    // Reset while the controller is capturing read data.
    send(1'b0, 6'd0, '0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rwe",   32'(ram_RWE),   32'd0);
`ifndef RAM_CTRL_CLEAR_EN
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    rd_check("post_rst0", 6'd0, 8'h01);
`else
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("abort_clear_len", 32'(n), 32'(DEPTH + 1));
    rd_check("post_rst0", 6'd0, 8'h00);
`endif
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/single_port_ram_ctrl.md
# single_port_ram_ctrl

Request-side controller for the team's single-port RAM (8-bit data, 6-bit address, single RWE strobe, 1 = write). Accepts read/write requests on a valid/ready interface, sequences the RAM port one access at a time, and returns read data on a valid/ready response channel. It sits between any client logic and the RAM and is the only driver of the RAM's data_in/addr/RWE pins.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W
- clk  input  1  rising-edge clock, shared with RAM
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data; ignored for reads
- rsp_valid  output  1  read data available
- rsp_ready  input  1  client accepts read data
- rsp_rdata  output  DATA_W  read data
- ram_data_in  output  DATA_W  to RAM data_in
- ram_addr  output  ADDR_W  to RAM addr
- ram_RWE  output  1  to RAM RWE; 1 = write
- ram_data_out  input  DATA_W  from RAM data_out; valid one cycle after a read address is presented with RWE = 0

## Operation
- States: CLEAR (macro only), IDLE, WR, RD_ADDR, RD_DATA, RSP.
- req_ready = 1 only in IDLE; all other states hold it 0. A single request is outstanding at a time, so program order is preserved (read-after-write returns new data).
- Handshake: request accepted on a rising edge where req_valid && req_ready; req_we/addr/wdata captured into registers at that edge. Requests must hold stable until accepted.
- IDLE -> WR on accepted write; IDLE -> RD_ADDR on accepted read; otherwise stay.
- WR: ram_RWE = 1, ram_addr/ram_data_in = captured values, for exactly one cycle; -> IDLE.
- RD_ADDR: ram_RWE = 0, ram_addr = captured address; -> RD_DATA.
- RD_DATA: rsp_rdata <= ram_data_out at end of cycle; -> RSP.
- RSP: rsp_valid = 1, rsp_rdata stable; -> IDLE on edge with rsp_ready = 1; holds indefinitely while rsp_ready = 0.
- ram_RWE is 0 in every state except WR and CLEAR; ram_addr and ram_data_in hold their last driven values when idle.
- rsp_rdata holds last read value outside RSP; rsp_valid = 0 outside RSP.

## Timing
- Reset values (cycle rst is sampled high and the next): req_ready 0, rsp_valid 0, rsp_rdata 0, ram_RWE 0, ram_addr 0, ram_data_in 0, state IDLE (or CLEAR with macro).
- req_ready = 1 first cycle after rst deasserts (no macro).
- Write accepted at edge T: ram_RWE = 1 during cycle T+1, RAM writes at end of T+1; req_ready = 1 in cycle T+2. Throughput: one write per 2 cycles.
- Read accepted at edge T: address on RAM during T+1; data captured end of T+2; rsp_valid = 1 from cycle T+3. With rsp_ready tied 1, req_ready returns in T+4.
- rst high in any state aborts the access: ram_RWE forced 0 in the same clocked update, pending response dropped, no partial write beyond the already-completed WR cycle.
- rsp_ready asserted outside RSP has no effect.

## Configuration
- RAM_CTRL_CLEAR_EN defined: after reset the FSM enters CLEAR, writing 0 to addresses 0 .. 2**ADDR_W-1 in order, one per cycle (ram_RWE = 1, ram_addr = counter, ram_data_in = 0); req_ready = 0 throughout; after address 2**ADDR_W-1 (63 by default) it moves to IDLE, so req_ready first rises 2**ADDR_W cycles after reset deasserts. Counter must not wrap to re-clear. Reset during CLEAR restarts it at address 0.
- Not defined: no CLEAR state; RAM contents after reset are whatever the RAM holds; IDLE directly after reset.

## Test plan
- Write 0x01@0, 0x02@1, 0x03@2 back-to-back, then read 0, 1, 2 with rsp_ready = 1 -> rsp_rdata 0x01, 0x02, 0x03 each at T+3 of acceptance; ram_RWE pulses exactly 3 single cycles.
- Overwrite 0x04@1 then read 1 immediately -> 0x04 (read-after-write ordering).
- Read 2 with rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_rdata = 0x03 stable 4 cycles, req_ready 0 throughout, no RAM write.
- Assert rst during RD_DATA -> next cycle rsp_valid 0, ram_RWE 0, req_ready 1 after deassert; subsequent read of 0 returns 0x01.
- req_valid held with req_ready 0 during WR -> request accepted only when req_ready returns 1, captured once.
- With RAM_CTRL_CLEAR_EN: preload 0xAA@63, reset -> req_ready low 64 cycles; read 63 and 0 -> 0x00 each.
